ppm_rx_decoder: RTL and testbench

Decodes the receiver's PPM pulse train into NUM_CH 12-bit stick/switch values scaled 0..1000, feeding the throttle, stick and arm logic of the flight-controller top level. Runs directly on the 50 MHz system clock with an internal 1 µs tick. Validates every frame before an atomic update of all channels. Reports link health and optionally forces safe outputs when the link is lost.

---
 rtl/ppm_pkg.sv | 32 +++
 rtl/ppm_sync_edge.sv | 30 +++
 rtl/ppm_rx_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_ppm_rx_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// Shared types, widths and helpers for the PPM receiver decoder.
package ppm_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_GAP     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_TAIL    = 2'd3
  } ppm_state_t;

  localparam int CH_W         = 12;
  localparam int US_W         = 13;
  localparam int CH_MAX       = 1000;
  localparam int CH_OFFSET_US = 1000;

  localparam logic [CH_W-1:0] CH_FAILSAFE = 12'd0;
  localparam logic [US_W-1:0] US_SAT      = 13'd8191;

  // Maps a channel interval in microseconds onto the 0..CH_MAX stick range.
  function automatic logic [CH_W-1:0] us_to_ch(input logic [US_W-1:0] us);
    logic [US_W-1:0] diff;
    diff = us - US_W'(CH_OFFSET_US);
    if (us <= US_W'(CH_OFFSET_US)) begin
      return 12'd0;
    end else if (us >= US_W'(CH_OFFSET_US + CH_MAX)) begin
      return CH_W'(CH_MAX);
    end else begin
      return diff[CH_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ppm_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector for an async pin.
module ppm_sync_edge (
  input  logic CLK,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic rise_r;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      rise_r  <= sync2_r & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/ppm_rx_decoder.sv
// PPM frame decoder: measures rising-to-rising intervals, validates whole frames, commits
// all channels atomically. Define PPM_FAILSAFE_EN to force ch to the failsafe value while the link is lost.
module ppm_rx_decoder
  import ppm_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NUM_CH     = 6,
  parameter int SYNC_US    = 3000,
  parameter int MIN_US     = 800,
  parameter int MAX_US     = 2200,
  parameter int TIMEOUT_MS = 100
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            ppm_in,
  output logic [CH_W-1:0] ch [NUM_CH],
  output logic            frame_strobe,
  output logic            link_ok,
  output logic [7:0]      err_count
);

  localparam int DIV   = CLK_HZ / 1_000_000;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             rise_s;
  logic             tick_s;
  logic             sync_s;
  logic             in_range_s;
  logic             commit_s;
  logic             reject_s;
  logic             store_s;
  logic             idx_clr_s;
  logic             idx_inc_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic [US_W-1:0]  us_cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [CH_W-1:0]  shadow_r [NUM_CH];
  logic [CH_W-1:0]  ch_r [NUM_CH];
  logic             frame_strobe_r;
  logic             link_ok_r;
  logic [7:0]       err_cnt_r;
  logic [9:0]       sub_ms_r;
  logic [15:0]      ms_cnt_r;
  ppm_state_t       state_r;
  ppm_state_t       state_nx;

  ppm_sync_edge u_sync (
    .CLK  (CLK),
    .rst  (rst),
    .din  (ppm_in),
    .rise (rise_s)
  );

  assign tick_s     = (div_cnt_r == DIV_W'(DIV - 1));
  assign sync_s     = (us_cnt_r >= US_W'(SYNC_US));
  assign in_range_s = (us_cnt_r >= US_W'(MIN_US)) && (us_cnt_r <= US_W'(MAX_US));

  // The edge cycle is the first cycle of the new interval, so us_cnt reads whole microseconds.
  always_ff @(posedge CLK) begin
    if (rst) begin
      div_cnt_r <= '0;
      us_cnt_r  <= '0;
    end else if (rise_s) begin
      div_cnt_r <= (DIV > 1) ? DIV_W'(1) : '0;
      us_cnt_r  <= (DIV > 1) ? '0 : US_W'(1);
    end else begin
      div_cnt_r <= tick_s ? '0 : div_cnt_r + DIV_W'(1);
      if (tick_s && (us_cnt_r != US_SAT)) begin
        us_cnt_r <= us_cnt_r + US_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_nx;
    end
  end

  // A rising edge always wins over a simultaneous sync timeout.
  always_comb begin
    state_nx  = state_r;
    commit_s  = 1'b0;
    reject_s  = 1'b0;
    store_s   = 1'b0;
    idx_clr_s = 1'b0;
    idx_inc_s = 1'b0;
    case (state_r)
      ST_HUNT: begin
        if (sync_s) begin
          state_nx = ST_GAP;
        end else begin
          state_nx = ST_HUNT;
        end
      end
      ST_GAP: begin
        if (rise_s) begin
          state_nx  = ST_MEASURE;
          idx_clr_s = 1'b1;
        end else begin
          state_nx = ST_GAP;
        end
      end
      ST_MEASURE: begin
        if (rise_s) begin
          if (in_range_s) begin
            store_s = 1'b1;
            if (idx_r == IDX_W'(NUM_CH - 1)) begin
              state_nx = ST_TAIL;
            end else begin
              idx_inc_s = 1'b1;
            end
          end else begin
            reject_s = 1'b1;
            state_nx = ST_HUNT;
          end
        end else if (sync_s) begin
          reject_s = 1'b1;
          state_nx = ST_GAP;
        end else begin
          state_nx = ST_MEASURE;
        end
      end
      ST_TAIL: begin
        if (rise_s) begin
          reject_s = 1'b1;
          state_nx = ST_HUNT;
        end else if (sync_s) begin
          commit_s = 1'b1;
          state_nx = ST_GAP;
        end else begin
          state_nx = ST_TAIL;
        end
      end
      default: begin
        state_nx = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      idx_r          <= '0;
      frame_strobe_r <= 1'b0;
      err_cnt_r      <= 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_r[i] <= '0;
        ch_r[i]     <= '0;
      end
    end else begin
      frame_strobe_r <= commit_s;
      if (idx_clr_s) begin
        idx_r <= '0;
      end else if (idx_inc_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end
      if (store_s) begin
        shadow_r[idx_r] <= us_to_ch(us_cnt_r);
      end
      if (commit_s) begin
        ch_r <= shadow_r;
      end
      if (reject_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  // Link supervision: milliseconds since the last committed frame, saturating at the timeout.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sub_ms_r  <= 10'd0;
      ms_cnt_r  <= 16'd0;
      link_ok_r <= 1'b0;
    end else if (commit_s) begin
      sub_ms_r  <= 10'd0;
      ms_cnt_r  <= 16'd0;
      link_ok_r <= 1'b1;
    end else begin
      if (tick_s) begin
        if (sub_ms_r == 10'd999) begin
          sub_ms_r <= 10'd0;
          if (ms_cnt_r < 16'(TIMEOUT_MS)) begin
            ms_cnt_r <= ms_cnt_r + 16'd1;
          end
        end else begin
          sub_ms_r <= sub_ms_r + 10'd1;
        end
      end
      if (ms_cnt_r == 16'(TIMEOUT_MS)) begin
        link_ok_r <= 1'b0;
      end
    end
  end

`ifdef PPM_FAILSAFE_EN
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch[i] = link_ok_r ? ch_r[i] : CH_FAILSAFE;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch[i] = ch_r[i];
    end
  end
`endif

  assign frame_strobe = frame_strobe_r;
  assign link_ok      = link_ok_r;
  assign err_count    = err_cnt_r;

endmodule

// File: tb/tb_ppm_rx_decoder.sv
// Randomised frame stimulus with a scoreboard: expected commits are queued when a frame is
// sent and popped by an independent monitor whenever frame_strobe fires.
module tb_ppm_rx_decoder;

  localparam int CLK_HZ     = 1_000_000;
  localparam int NUM_CH     = 6;
  localparam int SYNC_US    = 2300;
  localparam int MIN_US     = 800;
  localparam int MAX_US     = 2200;
  localparam int TIMEOUT_MS = 4;
  localparam int PW         = 300;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        ppm_in = 1'b0;
  logic [11:0] ch [NUM_CH];
  logic        frame_strobe;
  logic        link_ok;
  logic [7:0]  err_count;

  ppm_rx_decoder #(
    .CLK_HZ     (CLK_HZ),
    .NUM_CH     (NUM_CH),
    .SYNC_US    (SYNC_US),
    .MIN_US     (MIN_US),
    .MAX_US     (MAX_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .ppm_in       (ppm_in),
    .ch           (ch),
    .frame_strobe (frame_strobe),
    .link_ok      (link_ok),
    .err_count    (err_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int last_strobe_cyc = 0;
  int strobes = 0;
  int n_exp_commit = 0;
  int exp_err = 0;
  int stab_bad = 0;
  int iv[$];
  logic [NUM_CH-1:0][11:0] exp_q[$];
  logic [NUM_CH-1:0][11:0] last_commit = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is good only with exactly NUM_CH in-range intervals.
  function automatic bit frame_ok();
    if (iv.size() != NUM_CH) return 1'b0;
    foreach (iv[i]) if (iv[i] < MIN_US || iv[i] > MAX_US) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [11:0] expect_val(input int us);
    int v;
    v = us - 1000;
    if (v < 0) v = 0;
    if (v > 1000) v = 1000;
    return 12'(v);
  endfunction

  task automatic pulse(input int period);
    ppm_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (PW) @(negedge CLK);
    ppm_in = 1'b0;
    repeat (period - PW) @(negedge CLK);
  endtask

  task automatic rand_frame(input int n, input int lo, input int hi);
    iv.delete();
    repeat (n) iv.push_back(int'($urandom_range(hi, lo)));
  endtask

  task automatic send_frame();
    logic [NUM_CH-1:0][11:0] e;
    int gap;
    gap = SYNC_US + int'($urandom_range(200, 100));
    if (frame_ok()) begin
      for (int i = 0; i < NUM_CH; i++) e[i] = expect_val(iv[i]);
      exp_q.push_back(e);
      last_commit = e;
      n_exp_commit++;
    end else if (exp_err < 255) begin
      exp_err++;
    end
    for (int k = 0; k <= iv.size(); k++) pulse((k < iv.size()) ? iv[k] : gap);
    check("err_count", err_count, exp_err);
    check("commit_pending", exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each strobe and tracks the held channel values.
  logic [NUM_CH-1:0][11:0] exp_held = '0;
  logic [NUM_CH-1:0][11:0] got;
  bit prev_strobe = 1'b0;
  always @(negedge CLK) begin
    if (rst) begin
      exp_held = '0;
      prev_strobe = 1'b0;
    end else begin
      if (prev_strobe) check("strobe_width", frame_strobe, 1'b0);
      if (frame_strobe && !prev_strobe) begin
        strobes++;
        last_strobe_cyc = cyc;
        check("strobe_latency", cyc - last_rise_cyc, SYNC_US + 4);
        check("link_at_strobe", link_ok, 1'b1);
        check("strobe_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          for (int i = 0; i < NUM_CH; i++) check($sformatf("ch%0d", i), ch[i], got[i]);
          exp_held = got;
        end
      end
      prev_strobe = frame_strobe;
`ifndef PPM_FAILSAFE_EN
      for (int i = 0; i < NUM_CH; i++) if (ch[i] !== exp_held[i]) stab_bad++;
`endif
    end
  end

  initial begin
    repeat (150000) @(posedge CLK);
    $display("FAIL watchdog cycle budget exceeded checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < NUM_CH; i++) check("reset_ch", ch[i], 12'd0);
    check("reset_strobe", frame_strobe, 1'b0);
    check("reset_link", link_ok, 1'b0);
    check("reset_err", err_count, 8'd0);
    rst = 1'b0;
    repeat (SYNC_US + 150) @(negedge CLK);
    check("no_commit_before_frame", strobes, 0);

    iv = '{1500, 1000, 2000, 1200, 1800, 1100};
    send_frame();
    check("link_after_first", link_ok, 1'b1);

    iv = '{1200, 700, 900};
    send_frame();

    iv = '{850, 2150, 800, 2200, 0, 0};
    iv[4] = int'($urandom_range(MAX_US, MIN_US));
    iv[5] = int'($urandom_range(MAX_US, MIN_US));
    send_frame();

    rand_frame(NUM_CH - 1, MIN_US, 1200);
    send_frame();
    rand_frame(NUM_CH, MIN_US, MAX_US);
    send_frame();

    while (cyc < last_strobe_cyc + TIMEOUT_MS * 1000 - 20) @(negedge CLK);
    check("link_before_timeout", link_ok, 1'b1);
    while (cyc < last_strobe_cyc + TIMEOUT_MS * 1000 + 20) @(negedge CLK);
    check("link_after_timeout", link_ok, 1'b0);
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef PPM_FAILSAFE_EN
      check("timeout_ch_failsafe", ch[i], 12'd0);
`else
      check("timeout_ch_hold", ch[i], last_commit[i]);
`endif
    end

    rand_frame(NUM_CH + 1, MIN_US, 1100);
    send_frame();
    check("link_still_lost", link_ok, 1'b0);
    rand_frame(NUM_CH, MIN_US, MAX_US);
    send_frame();
    check("link_restored", link_ok, 1'b1);

    pulse(1500);
    pulse(1500);
    rst = 1'b1;
    exp_err = 0;
    last_commit = '0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < NUM_CH; i++) check("midreset_ch", ch[i], 12'd0);
    check("midreset_err", err_count, 8'd0);
    check("midreset_link", link_ok, 1'b0);
    check("midreset_strobe", frame_strobe, 1'b0);
    rst = 1'b0;
    repeat (SYNC_US + 150) @(negedge CLK);
    rand_frame(NUM_CH, MIN_US, MAX_US);
    send_frame();

    repeat (10) @(negedge CLK);
    check("strobe_count", strobes, n_exp_commit);
    check("ch_stable_cycles", stab_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
